axis_decimator: RTL

Parametrised AXI4-Stream rate reducer placed between the ADC/filter stream and the downstream FIFO/DMA path. It reduces the sample rate by an arbitrary runtime integer ratio, not just a power of two, in either pick mode (keep one sample per frame) or average mode (sum a frame, scale, saturate). Backpressure is honoured on both sides, and the output is fully registered.

---
 rtl/axis_decimator_pkg.sv | 12 +
 rtl/axis_decimator_sat.sv | 28 ++
 rtl/axis_decimator.sv | 127 ++++++++++++
 3 files changed

// File: rtl/axis_decimator_pkg.sv
// Shared constants and helpers for the axis_decimator stream rate reducer.
package axis_decimator_pkg;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    // Frame sums of up to 2^ratio_width-1 samples fit without overflow.
    function automatic int acc_width(input int data_width, input int ratio_width);
        return data_width + ratio_width;
    endfunction

endpackage

// File: rtl/axis_decimator_sat.sv
// Arithmetic right shift followed by signed saturation from IN_WIDTH to OUT_WIDTH bits.
module axis_decimator_sat #(
    parameter int IN_WIDTH    = 48,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic [IN_WIDTH-1:0]    din,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   dout
);

    logic signed [IN_WIDTH-1:0]    shifted;
    logic [IN_WIDTH-OUT_WIDTH:0]   upper;

    always_comb begin
        shifted = $signed(din) >>> shift;
        upper   = shifted[IN_WIDTH-1:OUT_WIDTH-1];
        // In range only when all bits above the output sign bit copy it.
        if ((&upper) || (~|upper)) begin
            dout = shifted[OUT_WIDTH-1:0];
        end else if (upper[IN_WIDTH-OUT_WIDTH]) begin
            dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/axis_decimator.sv
// AXI4-Stream decimator: pick or average one output per N-beat frame.
// Average mode, shift and saturation exist only when AXIS_DECIMATOR_AVG_EN is defined.
module axis_decimator
    import axis_decimator_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int RATIO_WIDTH      = 16,
    parameter int SHIFT_WIDTH      = 5
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [RATIO_WIDTH-1:0]      ratio,
    input  logic                        mode,
    input  logic [SHIFT_WIDTH-1:0]      shift,
    output logic [31:0]                 frame_count,
    output logic                        S_AXIS_tready,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

    localparam logic [RATIO_WIDTH-1:0] ONE = {{(RATIO_WIDTH-1){1'b0}}, 1'b1};

    logic [RATIO_WIDTH-1:0]      pos;
    logic [RATIO_WIDTH-1:0]      n_q;
    logic [RATIO_WIDTH-1:0]      ratio_eff;
    logic [RATIO_WIDTH-1:0]      n_cur;
    logic                        in_beat;
    logic                        out_beat;
    logic                        frame_start;
    logic                        frame_last;
    logic                        load;
    logic [AXIS_TDATA_WIDTH-1:0] load_data;

    // Output register is either empty or draining whenever input is accepted.
    assign S_AXIS_tready = ~M_AXIS_tvalid | M_AXIS_tready;
    assign in_beat       = S_AXIS_tvalid & S_AXIS_tready;
    assign out_beat      = M_AXIS_tvalid & M_AXIS_tready;
    assign frame_start   = (pos == '0);
    assign ratio_eff     = (ratio == '0) ? ONE : ratio;
    assign n_cur         = frame_start ? ratio_eff : n_q;
    assign frame_last    = (pos == (n_cur - ONE));

`ifdef AXIS_DECIMATOR_AVG_EN
    localparam int ACC_W = acc_width(AXIS_TDATA_WIDTH, RATIO_WIDTH);

    logic                        mode_q;
    logic                        mode_cur;
    logic [SHIFT_WIDTH-1:0]      shift_q;
    logic [SHIFT_WIDTH-1:0]      shift_cur;
    logic [ACC_W-1:0]            acc;
    logic [ACC_W-1:0]            acc_next;
    logic [ACC_W-1:0]            sample_ext;
    logic [AXIS_TDATA_WIDTH-1:0] sat_data;

    assign mode_cur   = frame_start ? mode : mode_q;
    assign shift_cur  = frame_start ? shift : shift_q;
    assign sample_ext = {{RATIO_WIDTH{S_AXIS_tdata[AXIS_TDATA_WIDTH-1]}}, S_AXIS_tdata};
    assign acc_next   = frame_start ? sample_ext : (acc + sample_ext);

    axis_decimator_sat #(
        .IN_WIDTH    (ACC_W),
        .OUT_WIDTH   (AXIS_TDATA_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_sat (
        .din   (acc_next),
        .shift (shift_cur),
        .dout  (sat_data)
    );

    assign load      = in_beat & ((mode_cur == MODE_AVG) ? frame_last : frame_start);
    assign load_data = (mode_cur == MODE_AVG) ? sat_data : S_AXIS_tdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc     <= '0;
            mode_q  <= MODE_PICK;
            shift_q <= '0;
        end else if (in_beat) begin
            acc <= acc_next;
            if (frame_start) begin
                mode_q  <= mode;
                shift_q <= shift;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{mode, shift};
    assign load       = in_beat & frame_start;
    assign load_data  = S_AXIS_tdata;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pos <= '0;
            n_q <= ONE;
        end else if (in_beat) begin
            pos <= frame_last ? '0 : (pos + ONE);
            if (frame_start) begin
                n_q <= ratio_eff;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            frame_count   <= '0;
        end else begin
            if (load) begin
                M_AXIS_tvalid <= 1'b1;
                M_AXIS_tdata  <= load_data;
            end else if (out_beat) begin
                M_AXIS_tvalid <= 1'b0;
            end
            if (out_beat) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule
